// File: rtl/des_pkg.sv
// DES key-schedule tables and helpers shared by the subkey generator.
// Holds the per-round shift table, the PC1/PC2 index tables (DES 1-based
// bit numbers), the FSM state enum and the 28-bit half rotations.
package des_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Left-shift amount for rounds 1..16, stored at index round-1
  localparam int unsigned SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // PC1: output bit i+1 (C0D0, MSB first) takes DES key bit PC1_TAB[i]
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  // PC2: subkey bit i+1 (MSB first) takes C/D bit PC2_TAB[i]
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Shift amount for a round, r0 = round-1; 1'b1 means shift by two
  function automatic logic shift_two(input logic [3:0] r0);
    return (SHIFT_TAB[r0] == 2);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] h, input logic two);
    return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] h, input logic two);
    return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction

  // C and D rotate independently
  function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic two);
    return {rotl28(cd[55:28], two), rotl28(cd[27:0], two)};
  endfunction

  function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic two);
    return {rotr28(cd[55:28], two), rotr28(cd[27:0], two)};
  endfunction

  // PC1 on a key whose MSB is DES bit 1; parity bits fall out here
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = key[64-PC1_TAB[i]];
    return r;
  endfunction

  // High if any key byte breaks the DES odd-parity rule
  function automatic logic key_parity_bad(input logic [63:0] key);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) bad = bad | ~(^key[b*8 +: 8]);
    return bad;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational DES PC2: 56-bit C/D register to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] subkey_o
);

  // PC2 discards eight C/D bits; fold them so the drop is explicit
  logic unused_cd;
  assign unused_cd = ^cd_i;

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign subkey_o[47-i] = cd_i[56-PC2_TAB[i]];
  end

endmodule

// File: rtl/des_key_stream.sv
// Sequential DES subkey generator: one C/D register rotated per transfer,
// streaming K1..K16 (encrypt) or K16..K1 (decrypt) over valid/ready.
// Optional feature macro: KEY_PARITY_CHECK_EN (flags even-parity key bytes).
module des_key_stream
  import des_pkg::*;
#(
  parameter bit IDLE_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [4:0]  subkey_idx,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic        done_q, done_d;
  logic        xfer;
  logic [47:0] pc2_w;

  // Key parity bits never reach PC1; fold the whole key so none dangle
  logic unused_key;
  assign unused_key = ^key;

  // Next-state: load restarts from any state; a transfer advances the schedule
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    xfer    = (state_q == RUN) && subkey_ready;
    if (load) begin
      // Decrypt starts from C16D16, which equals C0D0 after 28 total shifts
      state_d = RUN;
      cd_d    = decrypt ? pc1(key) : rotl_cd(pc1(key), 1'b0);
      cnt_d   = 5'd1;
      dir_d   = decrypt;
    end else if (xfer) begin
      if (cnt_q == 5'd16) begin
        state_d = IDLE;
        cnt_d   = 5'd0;
        done_d  = 1'b1;
      end else begin
        // Encrypt moves to round cnt+1; decrypt undoes round 17-cnt
        cd_d  = dir_q ? rotr_cd(cd_q, shift_two(4'(5'd16 - cnt_q)))
                      : rotl_cd(cd_q, shift_two(cnt_q[3:0]));
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  // State and schedule registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i     (cd_q),
    .subkey_o (pc2_w)
  );

  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign done         = done_q;
  assign subkey_idx   = subkey_valid ? (dir_q ? 5'd17 - cnt_q : cnt_q) : 5'd0;
  assign subkey       = (IDLE_ZERO && !subkey_valid) ? 48'h0 : pc2_w;

`ifdef KEY_PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;

  // Parity verdict captured on each load, held until the next load or reset
  always_comb begin
    parity_err_d = parity_err_q;
    if (load) parity_err_d = key_parity_bad(key);
  end

  // Parity flag register
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_stream.sv
// Directed bench for des_key_stream using the classic 133457799BBCDFF1 schedule.
module tb_des_key_stream;

  logic        clk = 1'b0;
  logic        rst, load, decrypt, subkey_ready;
  logic [63:0] key;
  logic [47:0] subkey;
  logic        subkey_valid, busy, done, parity_err;
  logic [4:0]  subkey_idx;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef KEY_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_A0  = 64'h133457799BBCDFF0;
  localparam logic [63:0] KEY_ONE = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] KEY_ZER = 64'h0101010101010101;

  always #5 clk = ~clk;

  des_key_stream dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .key          (key),
    .decrypt      (decrypt),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey_idx   (subkey_idx),
    .busy         (busy),
    .done         (done),
    .parity_err   (parity_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hand-derived subkeys: set 0 = KEY_A schedule, 1 = all zeros, 2 = all ones
  function automatic logic [47:0] exp_key(input int kset, input int idx);
    if (kset == 1) return 48'h0;
    if (kset == 2) return 48'hFFFFFFFFFFFF;
    case (idx)
      1:  return 48'h1B02EFFC7072;
      2:  return 48'h79AED9DBC9E5;
      3:  return 48'h55FC8A42CF99;
      4:  return 48'h72ADD6DB351D;
      5:  return 48'h7CEC07EB53A8;
      6:  return 48'h63A53E507B2F;
      7:  return 48'hEC84B7F618BC;
      8:  return 48'hF78A3AC13BFB;
      9:  return 48'hE0DBEBEDE781;
      10: return 48'hB1F347BA464F;
      11: return 48'h215FD3DED386;
      12: return 48'h7571F59467E9;
      13: return 48'h97C5D1FABA41;
      14: return 48'h5F43B7F2E73A;
      15: return 48'hBF918D3D3F0A;
      16: return 48'hCB3D8B0E17F5;
      default: return 48'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] k, input logic dec);
    load = 1'b1; key = k; decrypt = dec;
    tick();
    load = 1'b0; key = 64'hDEADBEEFDEADBEEF; decrypt = ~dec;
  endtask

  // Consume a stream already presenting its first subkey; every cycle is checked
  task automatic drain(input int kset, input logic dec, input int stall_pct);
    int n = 0;
    int cyc = 0;
    int e;
    logic rdy;
    while (n < 16 && cyc < 400) begin
      e = dec ? 16 - n : n + 1;
      chk("valid", 64'(subkey_valid), 64'(1'b1));
      chk("busy", 64'(busy), 64'(1'b1));
      chk("idx", 64'(subkey_idx), 64'(e));
      chk("subkey", 64'(subkey), 64'(exp_key(kset, e)));
      chk("done_mid", 64'(done), 64'(1'b0));
      rdy = ($urandom_range(99) >= stall_pct);
      subkey_ready = rdy;
      tick();
      cyc++;
      if (rdy) n++;
    end
    subkey_ready = 1'b0;
    chk("stream_len", 64'(n), 64'(16));
    chk("done_pulse", 64'(done), 64'(1'b1));
    chk("valid_end", 64'(subkey_valid), 64'(1'b0));
    chk("busy_end", 64'(busy), 64'(1'b0));
    chk("idx_end", 64'(subkey_idx), 64'(0));
    chk("subkey_end", 64'(subkey), 64'(0));
    tick();
    chk("done_once", 64'(done), 64'(1'b0));
  endtask

  task automatic run_stream(input logic [63:0] k, input logic dec, input int stall_pct,
                            input int kset, input logic par_bad);
    do_load(k, dec);
    chk("parity", 64'(parity_err), 64'(PAR_EN & par_bad));
    drain(kset, dec, stall_pct);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; decrypt = 1'b0; subkey_ready = 1'b0; key = '0;
    tick(); tick();
    chk("rst_valid", 64'(subkey_valid), 64'(0));
    chk("rst_idx", 64'(subkey_idx), 64'(0));
    chk("rst_subkey", 64'(subkey), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_parity", 64'(parity_err), 64'(0));
    rst = 1'b0;
    tick();

    // Encrypt then decrypt, back-to-back rate
    run_stream(KEY_A, 1'b0, 0, 0, 1'b0);
    run_stream(KEY_A, 1'b1, 0, 0, 1'b0);
    // Stalls: held subkey/idx checked on every stalled cycle
    run_stream(KEY_A, 1'b0, 40, 0, 1'b0);
    run_stream(KEY_A, 1'b1, 40, 0, 1'b0);
    // Keys whose only set bits are parity bits or non-parity bits
    run_stream(KEY_ZER, 1'b0, 0, 1, 1'b0);
    run_stream(KEY_ONE, 1'b1, 0, 2, 1'b0);

    // Abort at transfer 7 with a same-cycle transfer; restart on a new key
    do_load(KEY_A, 1'b0);
    for (int t = 1; t <= 6; t++) begin
      chk("abort_pre_idx", 64'(subkey_idx), 64'(t));
      subkey_ready = 1'b1;
      tick();
    end
    chk("abort_at_idx", 64'(subkey_idx), 64'(7));
    chk("abort_at_key", 64'(subkey), 64'(exp_key(0, 7)));
    subkey_ready = 1'b1;
    do_load(KEY_ONE, 1'b0);
    subkey_ready = 1'b0;
    chk("abort_no_done", 64'(done), 64'(0));
    drain(2, 1'b0, 0);

    // Reset mid-stream at idx 9
    do_load(KEY_A, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      subkey_ready = 1'b1;
      tick();
    end
    subkey_ready = 1'b0;
    chk("pre_rst_idx", 64'(subkey_idx), 64'(9));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(subkey_valid), 64'(0));
    chk("mid_rst_idx", 64'(subkey_idx), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_subkey", 64'(subkey), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));

    // rst and load together: rst wins
    rst = 1'b1;
    do_load(KEY_A, 1'b0);
    rst = 1'b0;
    chk("rst_load_valid", 64'(subkey_valid), 64'(0));
    chk("rst_load_idx", 64'(subkey_idx), 64'(0));
    run_stream(KEY_A, 1'b0, 0, 0, 1'b0);

    // Bad parity key still streams; flag holds, then clears on a good load
    run_stream(KEY_A0, 1'b0, 0, 0, 1'b1);
    chk("parity_hold", 64'(parity_err), 64'(PAR_EN));
    run_stream(KEY_A, 1'b1, 0, 0, 1'b0);
    do_load(KEY_A0, 1'b0);
    chk("parity_set2", 64'(parity_err), 64'(PAR_EN));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("parity_rst", 64'(parity_err), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
